load_unit: RTL and testbench



---
 rtl/load_unit_pkg.sv | 40 ++++
 rtl/load_extract.sv | 43 ++++
 rtl/load_unit.sv | 166 ++++++++++++++++
 tb/tb_load_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared encodings for the sequential load-size unit.
// Misaligned-access trapping is controlled by LOAD_UNIT_MISALIGN_TRAP_EN.
package load_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_DBL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_SIZE     = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd0;
            SZ_HALF: return 3'd1;
            SZ_WORD: return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Lane select and zero/sign extension of a loaded field.
// Purely combinational; offset is expected to be naturally aligned.
module load_extract
    import load_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = off_w(DATA_W)
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    output logic [DATA_W-1:0] result_o
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              msb;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        mask    = '1;
        msb     = shifted[DATA_W-1];
        unique case (size_i)
            SZ_BYTE: begin
                mask = DATA_W'(8'hFF);
                msb  = shifted[7];
            end
            SZ_HALF: begin
                mask = DATA_W'(16'hFFFF);
                msb  = shifted[15];
            end
            SZ_WORD: begin
                mask = DATA_W'(32'hFFFF_FFFF);
                msb  = shifted[31];
            end
            default: ;
        endcase
        result_o = (shifted & mask)
                 | ((sign_ext_i && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/load_unit.sv
// Sequential load-size unit: one word read, timeout, lane extract.
// Define LOAD_UNIT_MISALIGN_TRAP_EN to trap misaligned loads.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       addr,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] load_data,
    output logic [1:0]        err_code
);

    localparam int OFF_W = off_w(DATA_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

`ifdef LOAD_UNIT_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic [31:0]       maddr_q, maddr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    err_e              err_q, err_d;

    logic [OFF_W-1:0]  off_in;
    logic              mis_in;
    logic              bad_size;
    logic [OFF_W-1:0]  off_eff;
    logic [DATA_W-1:0] ext;

    assign off_in   = addr[OFF_W-1:0];
    assign mis_in   = |(off_in & OFF_W'(lane_mask(size)));
    assign bad_size = (size == SZ_DBL) && (DATA_W < 64);

    // Untrapped misalignment rounds the lane down to natural alignment.
    assign off_eff = off_q & ~OFF_W'(lane_mask(size_q));

    load_extract #(
        .DATA_W (DATA_W)
    ) u_extract (
        .rdata_i    (mem_rdata),
        .off_i      (off_eff),
        .size_i     (size_q),
        .sign_ext_i (sext_q),
        .result_o   (ext)
    );

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        sext_d  = sext_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        maddr_d = maddr_q;
        done_d  = 1'b0;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    off_d  = off_in;
                    size_d = size;
                    sext_d = sign_ext;
                    if (bad_size) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = ERR_SIZE;
                        data_d  = '0;
                    end else if (TRAP_EN && mis_in) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = ERR_MISALIGN;
                        data_d  = '0;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        maddr_d = {addr[31:OFF_W], {OFF_W{1'b0}}};
                        err_d   = ERR_OK;
                    end
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    data_d  = ext;
                    err_d   = ERR_OK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        data_d  = '0;
                        err_d   = ERR_TIMEOUT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            off_q   <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            maddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            maddr_q <= maddr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_addr  = maddr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign load_data = data_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_load_unit.sv
// Randomized bench for load_unit (32- and 64-bit instances).
// Expected results come from an arithmetic reference model.
`timescale 1ns/1ps
module tb_load_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start32 = 1'b0;
    logic        start64 = 1'b0;
    logic [31:0] addr_i = '0;
    logic [1:0]  size_i = '0;
    logic        sext_i = 1'b0;
    logic [63:0] rdata = '0;
    logic        rvalid = 1'b0;

    logic        req32, busy32, done32;
    logic [31:0] maddr32, ld32;
    logic [1:0]  err32;
    logic        req64, busy64, done64;
    logic [31:0] maddr64;
    logic [63:0] ld64;
    logic [1:0]  err64;

    always #5 clk = ~clk;

    load_unit #(.DATA_W(32), .TIMEOUT(TO)) u32 (
        .clk(clk), .reset_n(reset_n), .start(start32),
        .addr(addr_i), .size(size_i), .sign_ext(sext_i),
        .mem_req(req32), .mem_addr(maddr32),
        .mem_rdata(rdata[31:0]), .mem_rvalid(rvalid),
        .busy(busy32), .done(done32),
        .load_data(ld32), .err_code(err32)
    );

    load_unit #(.DATA_W(64), .TIMEOUT(TO)) u64 (
        .clk(clk), .reset_n(reset_n), .start(start64),
        .addr(addr_i), .size(size_i), .sign_ext(sext_i),
        .mem_req(req64), .mem_addr(maddr64),
        .mem_rdata(rdata), .mem_rvalid(rvalid),
        .busy(busy64), .done(done64),
        .load_data(ld64), .err_code(err64)
    );

    bit          sel64 = 1'b0;
    logic        o_req, o_busy, o_done;
    logic [31:0] o_maddr;
    logic [63:0] o_ld;
    logic [1:0]  o_err;

    assign o_req   = sel64 ? req64 : req32;
    assign o_busy  = sel64 ? busy64 : busy32;
    assign o_done  = sel64 ? done64 : done32;
    assign o_maddr = sel64 ? maddr64 : maddr32;
    assign o_ld    = sel64 ? ld64 : {32'b0, ld32};
    assign o_err   = sel64 ? err64 : err32;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: load result straight from the size/offset rules.
    function automatic void model(input bit w64, input logic [31:0] a,
                                  input logic [1:0] sz, input bit sx,
                                  input logic [63:0] rd,
                                  output logic [1:0] err,
                                  output logic [63:0] val);
        int dw, nb, off;
        logic [127:0] word, f, lim;
        dw   = w64 ? 64 : 32;
        nb   = 1 << sz;
        off  = int'(a % (dw / 8));
        lim  = 128'd1 << dw;
        word = 128'(rd) % lim;
        err  = 2'd0;
        val  = '0;
        if (nb * 8 > dw) begin
            err = 2'd3;
            return;
        end
        if (off % nb != 0) begin
`ifdef LOAD_UNIT_MISALIGN_TRAP_EN
            err = 2'd1;
            return;
`else
            off = off - off % nb;
`endif
        end
        f = (word >> (8 * off)) % (128'd1 << (8 * nb));
        if (sx && f >= (128'd1 << (8 * nb - 1)))
            f = f + (lim - (128'd1 << (8 * nb)));
        f   = f % lim;
        val = f[63:0];
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_req"},  64'(o_req),   64'd0);
        check({tag, "_busy"}, 64'(o_busy),  64'd0);
        check({tag, "_done"}, 64'(o_done),  64'd0);
        check({tag, "_err"},  64'(o_err),   64'd0);
        check({tag, "_data"}, o_ld,         64'd0);
        check({tag, "_addr"}, 64'(o_maddr), 64'd0);
    endtask

    // k: cycles from mem_req to rvalid (0 = never). poke: stray start.
    task automatic do_load(input bit w64, input logic [31:0] a,
                           input logic [1:0] sz, input bit sx,
                           input logic [63:0] rd, input int k,
                           input bit poke);
        logic [1:0]  e_err;
        logic [63:0] e_val;
        logic [31:0] r_addr;
        int e_cyc, reqs, done_at, c;
        bit early;
        model(w64, a, sz, sx, rd, e_err, e_val);
        early = (e_err != 2'd0);
        if (early) begin
            e_cyc = 1;
            poke  = 1'b0;
        end else if (k == 0) begin
            e_cyc = TO + 2;
            e_err = 2'd2;
            e_val = '0;
        end else begin
            e_cyc = k + 2;
        end
        reqs = 0;
        done_at = 0;
        r_addr = '0;
        c = 0;
        @(negedge clk);
        sel64 = w64;
        addr_i = a;
        size_i = sz;
        sext_i = sx;
        rdata = rd;
        if (w64) start64 = 1'b1;
        else start32 = 1'b1;
        while (done_at == 0 && c < TO + 4) begin
            @(negedge clk);
            c++;
            start32 = 1'b0;
            start64 = 1'b0;
            if (poke && c == 2) begin
                if (w64) start64 = 1'b1;
                else start32 = 1'b1;
                addr_i = ~a;
                size_i = ~sz;
                sext_i = ~sx;
            end
            rvalid = (k != 0 && c == k + 1);
            if (c == 1) check("busy", 64'(o_busy), 64'd1);
            if (o_req) begin
                reqs++;
                r_addr = o_maddr;
            end
            if (o_done) done_at = c;
        end
        rvalid = 1'b0;
        check("latency", 64'(done_at), 64'(e_cyc));
        check("err", 64'(o_err), 64'(e_err));
        check("data", o_ld, e_val);
        check("reqs", 64'(reqs), early ? 64'd0 : 64'd1);
        if (!early)
            check("maddr", 64'(r_addr), 64'(a & ~(w64 ? 32'd7 : 32'd3)));
        if (!early && k == 0) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                rvalid = 1'b1;
                @(negedge clk);
                rvalid = 1'b0;
                check("late_done", 64'(o_done), 64'd0);
                check("late_data", o_ld, 64'd0);
            end
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        sel64 = 1'b0;
        addr_i = 32'h0000_5004;
        size_i = 2'b10;
        sext_i = 1'b0;
        rdata = 64'h1234_5678;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_zero("rst_async");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1;
            @(negedge clk);
            check("rst_done", 64'(o_done), 64'd0);
            check("rst_busy", 64'(o_busy), 64'd0);
            check("rst_data", o_ld, 64'd0);
        end
        rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel64 = bit'(s);
            #1;
            check_zero("reset");
        end
        @(negedge clk);
        reset_n = 1'b1;

        do_load(1'b0, 32'h1001, 2'b00, 1'b1, 64'h8899AABB, 1, 1'b0);
        do_load(1'b0, 32'h1002, 2'b01, 1'b0, 64'h8899AABB, 2, 1'b0);
        do_load(1'b0, 32'h1001, 2'b01, 1'b0, 64'h8899AABB, 1, 1'b0);
        do_load(1'b0, 32'h2000, 2'b10, 1'b1, 64'h8899AABB, 0, 1'b0);
        do_load(1'b0, 32'h3000, 2'b11, 1'b0, 64'h8899AABB, 1, 1'b0);
        do_load(1'b1, 32'h4000, 2'b11, 1'b0,
                64'h0123456789ABCDEF, 1, 1'b0);
        do_load(1'b1, 32'h4006, 2'b01, 1'b1,
                64'h89AB0123456789AB, 3, 1'b1);
        do_load(1'b0, 32'h6003, 2'b00, 1'b0, 64'h7F00_0000, 4, 1'b1);

        for (int i = 0; i < 40; i++)
            do_load(bit'($urandom_range(0, 1)), $urandom,
                    2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                    {$urandom, $urandom}, $urandom_range(0, 5),
                    bit'($urandom_range(0, 1)));

        reset_mid();
        do_load(1'b0, 32'h7002, 2'b01, 1'b1, 64'h8001_0000, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
